seq_divider4: RTL and testbench

Multi-cycle unsigned 4-bit divider controller that time-shares one subtract-with-borrow datapath over four restoring-division iterations. It sits beside the arithmetic-circuit library and lets a requester obtain quotient and remainder through a start/done handshake. It uses one trial subtraction per clock instead of a combinational array divider. The datapath subtractor lives inside this block; its borrow out decides each quotient bit.

---
 rtl/seq_divider4.sv | 104 ++++++++++
 tb/tb_seq_divider4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider4.sv
// Multi-cycle unsigned 4-bit restoring divider: one trial subtraction per clock,
// four iterations, start/done handshake with quotient, remainder and divide-by-zero flag.
module seq_divider4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, next_state;
  logic [3:0] a_sh;
  logic [3:0] b_reg;
  logic [3:0] r;
  logic [2:0] q;
  logic [1:0] count;

  logic       accept;
  logic [4:0] trial;
  logic [4:0] diff;
  logic       borrow;
  logic [3:0] r_next;
  logic       q_bit;

  // One restoring step: the borrow out of the trial subtraction picks the quotient bit.
  always_comb begin
    accept = start && (state != RUN);
    trial  = {r, a_sh[3]};
    diff   = trial - {1'b0, b_reg};
    borrow = diff[4];
    r_next = borrow ? trial[3:0] : diff[3:0];
    q_bit  = ~borrow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = (divisor == 4'd0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count == 2'd0) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) next_state = (divisor == 4'd0) ? DONE : RUN;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers are only written on entry to DONE, so they hold through a following RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh        <= 4'd0;
      b_reg       <= 4'd0;
      r           <= 4'd0;
      q           <= 3'd0;
      count       <= 2'd0;
      quotient    <= 4'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != 4'd0) begin
        a_sh  <= dividend;
        b_reg <= divisor;
        r     <= 4'd0;
        q     <= 3'd0;
        count <= 2'd3;
      end else begin
        quotient    <= 4'hF;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      a_sh  <= {a_sh[2:0], 1'b0};
      r     <= r_next;
      q     <= {q[1:0], q_bit};
      count <= count - 2'd1;
      if (count == 2'd0) begin
        quotient    <= {q, q_bit};
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: directed cases, exhaustive operand sweep and
// random operations compared against an arithmetic reference (A/B, A%B, zero rule).
module tb_seq_divider4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [3:0] expQ;
  logic [3:0] expR;
  logic       expZ;

  seq_divider4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Idle cycles: no handshake activity and the last results must hold.
  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 8'(busy), 8'd0);
      checkOutput("idle_done", 8'(done), 8'd0);
      checkOutput("idle_q", 8'(quotient), 8'(expQ));
      checkOutput("idle_r", 8'(remainder), 8'(expR));
      checkOutput("idle_dbz", 8'(div_by_zero), 8'(expZ));
    end
  endtask

  // Called at a negedge; drives start so the next rising edge accepts it, then follows
  // the operation to its done cycle and returns at the negedge inside that cycle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit intrude);
    logic [3:0] mq;
    logic [3:0] mr;
    if (b == 4'd0) begin
      mq = 4'hF;
      mr = a;
    end else begin
      mq = a / b;
      mr = a % b;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start = intrude && (k == 1);
        if (start) begin
          dividend = 4'($urandom);
          divisor  = 4'($urandom);
        end
        checkOutput("run_busy", 8'(busy), 8'd1);
        checkOutput("run_done", 8'(done), 8'd0);
        checkOutput("run_q_hold", 8'(quotient), 8'(expQ));
        checkOutput("run_r_hold", 8'(remainder), 8'(expR));
      end
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_pulse", 8'(done), 8'd1);
    checkOutput("done_busy", 8'(busy), 8'd0);
    checkOutput("quotient", 8'(quotient), 8'(mq));
    checkOutput("remainder", 8'(remainder), 8'(mr));
    checkOutput("div_by_zero", 8'(div_by_zero), 8'(b == 4'd0));
    expQ = mq;
    expR = mr;
    expZ = (b == 4'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 8'(busy), 8'd0);
    checkOutput({tag, "_done"}, 8'(done), 8'd0);
    checkOutput({tag, "_q"}, 8'(quotient), 8'd0);
    checkOutput({tag, "_r"}, 8'(remainder), 8'd0);
    checkOutput({tag, "_dbz"}, 8'(div_by_zero), 8'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    expQ     = 4'd0;
    expR     = 4'd0;
    expZ     = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    idleCheck(1);

    applyStimulus(4'd13, 4'd3, 1'b0);
    idleCheck(2);
    applyStimulus(4'd15, 4'd1, 1'b0);
    applyStimulus(4'd2, 4'd9, 1'b0);
    applyStimulus(4'd15, 4'd15, 1'b0);
    idleCheck(1);
    applyStimulus(4'd7, 4'd0, 1'b0);
    idleCheck(1);

    // Start pulse mid-RUN is ignored; start held in DONE is accepted back-to-back.
    applyStimulus(4'd13, 4'd3, 1'b1);
    applyStimulus(4'd9, 4'd2, 1'b0);
    idleCheck(1);

    // Reset in the middle of a run discards it without a done pulse.
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetState("midrun_rst");
    @(negedge clk);
    checkResetState("rst_held");
    rst  = 1'b0;
    expQ = 4'd0;
    expR = 4'd0;
    expZ = 1'b0;
    idleCheck(2);
    applyStimulus(4'd14, 4'd3, 1'b0);
    idleCheck(1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) idleCheck($urandom_range(1, 2));
      end
    end

    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 0) idleCheck(1);
    end
    idleCheck(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
